tx_pkt_scheduler: RTL and testbench
===================================

TX_PKT_SCHEDULER -- requirements
Module: tx_pkt_scheduler

Interface
REQ-001 Parameter BYTES, default 1, symbol width in bytes; BITS = 8*BYTES.
REQ-002 Parameter GAP_CYCLES, default 16, number of idle enabled cycles between packets (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum enabled cycles allowed in SEND (>=2).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 clk_enable  in  1  symbol-rate enable; all registers hold their value when low.
REQ-007 req  in  2  per-source packet request, level-sensitive.
REQ-008 s_len  in  32  {len1, len0}, per-source payload length, 16 bits each.
REQ-009 s_bpsk  in  2  per-source modulation flag, 1 = BPSK, 0 = QPSK.
REQ-010 s_tdata / s_tvalid / s_tlast  in  2*BITS / 2 / 2  per-source AXIS payload streams, packed.
REQ-011 s_tready  out  2  per-source AXIS ready.
REQ-012 m_tdata / m_tvalid / m_tlast / m_tuser  out  BITS / 1 / 1 / 1  AXIS stream to the packetizer input.
REQ-013 m_tready  in  1  packetizer input ready.
REQ-014 payload_length  out  16  length of the granted packet, to the packetizer.
REQ-015 mode_ctrl  out  4  packetizer mode select.
REQ-016 pkt_sent  in  1  packetizer completion flag.
REQ-017 grant  out  2  one-hot active source; busy  out  1  state != IDLE; timeout_err  out  1  sticky watchdog flag.

Function
REQ-018 The FSM SHALL be one-hot with states IDLE, SEND and GAP, and SHALL advance only on cycles where clk_enable=1.
REQ-019 In IDLE with req != 0, the block SHALL select sel round-robin: when exactly one req bit is set, that source wins; when both are set, the source other than last_grant wins.
REQ-020 On a grant, the block SHALL register grant = one-hot(sel), payload_length = len[sel], m_tuser = s_bpsk[sel] and last_grant = sel, and SHALL enter SEND on the same edge; the grant appears 1 cycle after req is sampled.
REQ-021 payload_length and m_tuser SHALL stay stable from the grant edge until the block leaves SEND.
REQ-022 In SEND, m_tdata/m_tvalid/m_tlast SHALL combinationally equal the selected source's stream, s_tready[sel] SHALL equal m_tready, and s_tready[~sel] SHALL be 0.
REQ-023 Outside SEND, m_tvalid SHALL be 0 and s_tready SHALL be 2'b00.
REQ-024 SEND SHALL transition to GAP on an enabled cycle with pkt_sent=1; grant SHALL clear to 00 on that edge.
REQ-025 A 16-bit watchdog SHALL count enabled cycles spent in SEND, starting from 1 on the first SEND cycle; if it reaches TIMEOUT_CYCLES without pkt_sent, timeout_err SHALL be set to 1, grant SHALL clear, and the FSM SHALL go to GAP.
REQ-026 If pkt_sent and the timeout occur in the same cycle, pkt_sent SHALL win and timeout_err SHALL remain unchanged.
REQ-027 GAP SHALL last exactly GAP_CYCLES enabled cycles and then enter IDLE; req SHALL be ignored during SEND and GAP.
REQ-028 Deassertion of req[sel] during SEND SHALL have no effect.
REQ-029 timeout_err SHALL be sticky and cleared only by reset.
REQ-030 mode_ctrl SHALL be 4'b0100 (MIX) from the first enabled cycle after reset onward.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, grant=00, last_grant=1, payload_length=0, m_tuser=1, mode_ctrl=4'b0000, timeout_err=0, the watchdog and gap counters to 0, and busy=0; reset SHALL abort any packet in progress, including one mid-SEND.

Verification
REQ-032 req=01, len0=8, bpsk0=1 -> next cycle grant=01, payload_length=8, m_tuser=1, and s0 data passes through; a pkt_sent pulse -> GAP for 16 cycles, then busy=0.
REQ-033 Immediately after reset, req=11 -> source 0 is granted first, then source 1 after its packet completes and the gap elapses.
REQ-034 req=11 held continuously for 4 packets -> grant sequence 01, 10, 01, 10.
REQ-035 TIMEOUT_CYCLES=100 with no pkt_sent -> timeout_err=1 on SEND cycle 100 and grant=00; IDLE follows GAP_CYCLES later, and timeout_err stays 1.
REQ-036 m_tready=0 in SEND -> s_tready=00; rst_n=0 mid-SEND -> every output at its reset value after that edge.
REQ-037 clk_enable=0 for 5 cycles mid-GAP -> the gap counter and state are frozen, and the total gap equals 16 enabled cycles.

Source files
------------

// File: rtl/tx_pkt_scheduler.sv
// Two-source round-robin TX packet scheduler feeding the packetizer.
// One-hot IDLE/SEND/GAP FSM with a SEND watchdog and inter-packet gap.
module tx_pkt_scheduler #(
    parameter int BYTES          = 1,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int BITS          = 8 * BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_enable,
    input  logic [1:0]        req,
    input  logic [31:0]       s_len,
    input  logic [1:0]        s_bpsk,
    input  logic [2*BITS-1:0] s_tdata,
    input  logic [1:0]        s_tvalid,
    input  logic [1:0]        s_tlast,
    output logic [1:0]        s_tready,
    output logic [BITS-1:0]   m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tuser,
    input  logic              m_tready,
    output logic [15:0]       payload_length,
    output logic [3:0]        mode_ctrl,
    input  logic              pkt_sent,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_SEND = 3'b010;
    localparam logic [2:0] S_GAP  = 3'b100;

    localparam logic [3:0]  MODE_MIX = 4'b0100;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] len_q, len_d;
    logic        tuser_q, tuser_d;
    logic [3:0]  mode_q, mode_d;
    logic        terr_q, terr_d;
    logic [15:0] wdog_q, wdog_d;
    logic [15:0] gap_q, gap_d;

    logic        pick;
    logic        in_send;

    assign in_send = state_q[1];

    // Round-robin pick; a lone requester wins outright.
    always_comb begin
        pick = 1'b0;
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        len_d   = len_q;
        tuser_d = tuser_q;
        mode_d  = mode_q;
        terr_d  = terr_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;
        if (clk_enable) begin
            mode_d = MODE_MIX;
            unique case (1'b1)
                state_q[0]: begin
                    if (|req) begin
                        state_d = S_SEND;
                        grant_d = pick ? 2'b10 : 2'b01;
                        last_d  = pick;
                        len_d   = pick ? s_len[31:16] : s_len[15:0];
                        tuser_d = s_bpsk[pick];
                        wdog_d  = 16'd1;
                    end
                end
                state_q[1]: begin
                    if (pkt_sent) begin
                        state_d = S_GAP;
                        grant_d = 2'b00;
                        gap_d   = 16'd0;
                        wdog_d  = 16'd0;
                    end else if (wdog_q == WD_LIMIT) begin
                        state_d = S_GAP;
                        grant_d = 2'b00;
                        terr_d  = 1'b1;
                        gap_d   = 16'd0;
                        wdog_d  = 16'd0;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end
                state_q[2]: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        gap_d   = 16'd0;
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            len_q   <= 16'd0;
            tuser_q <= 1'b1;
            mode_q  <= 4'b0000;
            terr_q  <= 1'b0;
            wdog_q  <= 16'd0;
            gap_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            tuser_q <= tuser_d;
            mode_q  <= mode_d;
            terr_q  <= terr_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
        end
    end

    // last_q doubles as the active source index while in SEND.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = 2'b00;
        if (in_send) begin
            m_tdata  = last_q ? s_tdata[2*BITS-1:BITS] : s_tdata[BITS-1:0];
            m_tvalid = s_tvalid[last_q];
            m_tlast  = s_tlast[last_q];
            s_tready[last_q] = m_tready;
        end
    end

    assign m_tuser        = tuser_q;
    assign payload_length = len_q;
    assign mode_ctrl      = mode_q;
    assign grant          = grant_q;
    assign busy           = ~state_q[0];
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// Scoreboard bench for tx_pkt_scheduler: grants, passthrough,
// round-robin order, gap length, watchdog and reset behaviour.
module tb_tx_pkt_scheduler;

    localparam int BITS = 8;
    localparam int GAP  = 16;
    localparam int TO   = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_enable;
    logic [1:0]      req;
    logic [31:0]     s_len;
    logic [1:0]      s_bpsk;
    logic [2*BITS-1:0] s_tdata;
    logic [1:0]      s_tvalid;
    logic [1:0]      s_tlast;
    logic [1:0]      s_tready;
    logic [BITS-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tuser;
    logic            m_tready;
    logic [15:0]     payload_length;
    logic [3:0]      mode_ctrl;
    logic            pkt_sent;
    logic [1:0]      grant;
    logic            busy;
    logic            timeout_err;

    tx_pkt_scheduler #(
        .BYTES(1),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_enable(clk_enable),
        .req(req),
        .s_len(s_len),
        .s_bpsk(s_bpsk),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .m_tready(m_tready),
        .payload_length(payload_length),
        .mode_ctrl(mode_ctrl),
        .pkt_sent(pkt_sent),
        .grant(grant),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0]  exp_grant_q[$];
    logic [15:0] exp_len_q[$];
    logic        exp_user_q[$];
    logic [8:0]  exp_beat_q[$];
    logic [8:0]  mon_exp;

    // Reset-state vector: grant,busy,len,tuser,mode,terr,tvalid,tready
    localparam logic [27:0] RST_VEC = {2'b00, 1'b0, 16'd0, 1'b1,
                                       4'b0000, 1'b0, 1'b0, 2'b00};

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            tests++;
            if (exp_beat_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected got=%h", {m_tlast, m_tdata});
            end else begin
                mon_exp = exp_beat_q.pop_front();
                if ({m_tlast, m_tdata} !== mon_exp) begin
                    fails++;
                    $display("FAIL beat got=%h exp=%h",
                             {m_tlast, m_tdata}, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        s_tvalid = 2'b00;
        s_tlast = 2'b00;
        pkt_sent = 1'b0;
        clk_enable = 1'b1;
        m_tready = 1'b1;
        step();
        rst_n = 1'b1;
        exp_grant_q.delete();
        exp_len_q.delete();
        exp_user_q.delete();
        exp_beat_q.delete();
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [15:0] l,
                            input logic u);
        exp_grant_q.push_back(g);
        exp_len_q.push_back(l);
        exp_user_q.push_back(u);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 2'b00 && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_sent();
        pkt_sent = 1'b1;
        step();
        pkt_sent = 1'b0;
    endtask

    task automatic count_gap(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic send_beats(input int src, input int nb,
                              input logic [7:0] base);
        logic [7:0] v;
        for (int i = 0; i < nb; i++) begin
            v = base + 8'(i);
            s_tdata = (src == 1) ? {v, ~v} : {~v, v};
            s_tvalid = 2'b11;
            s_tlast = (i == nb - 1) ? 2'b11 : 2'b00;
            exp_beat_q.push_back({(i == nb - 1), v});
            step();
        end
        s_tvalid = 2'b00;
        s_tlast = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({grant, busy, payload_length, m_tuser, mode_ctrl, timeout_err,
             m_tvalid, s_tready} !== RST_VEC) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h",
                     {grant, busy, payload_length, m_tuser, mode_ctrl,
                      timeout_err, m_tvalid, s_tready}, RST_VEC);
        end
        step();
        tests++;
        if (mode_ctrl !== 4'b0100 || grant !== 2'b00) begin
            fails++;
            $display("FAIL mode_after_reset got=%b/%b exp=0100/00",
                     mode_ctrl, grant);
        end
    endtask

    task automatic test_single();
        int n;
        logic [1:0] eg;
        logic [15:0] el;
        logic eu;
        do_reset();
        step();
        s_len = {16'd3, 16'd8};
        s_bpsk = 2'b01;
        push_exp(2'b01, 16'd8, 1'b1);
        req = 2'b01;
        tests++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL grant_early got=%b exp=00", grant);
        end
        step();
        eg = exp_grant_q.pop_front();
        el = exp_len_q.pop_front();
        eu = exp_user_q.pop_front();
        tests++;
        if ({grant, payload_length, m_tuser} !== {eg, el, eu}) begin
            fails++;
            $display("FAIL single_grant got=%b/%0d/%b exp=%b/%0d/%b",
                     grant, payload_length, m_tuser, eg, el, eu);
        end
        req = 2'b00;
        m_tready = 1'b0;
        s_tvalid = 2'b11;
        #1;
        tests++;
        if (s_tready !== 2'b00 || m_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL ready_low got=%b/%b exp=00/1", s_tready, m_tvalid);
        end
        m_tready = 1'b1;
        s_tvalid = 2'b00;
        #1;
        tests++;
        if (s_tready !== 2'b01) begin
            fails++;
            $display("FAIL ready_sel got=%b exp=01", s_tready);
        end
        send_beats(0, 8, 8'h10);
        pulse_sent();
        tests++;
        if (grant !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL sent_clear got=%b/%b exp=00/1", grant, busy);
        end
        count_gap(n);
        tests++;
        if (n != GAP) begin
            fails++;
            $display("FAIL gap_len got=%0d exp=%0d", n, GAP);
        end
    endtask

    task automatic test_rr_after_reset();
        int n;
        logic [1:0] eg;
        logic [15:0] el;
        logic eu;
        do_reset();
        step();
        s_len = {16'd9, 16'd5};
        s_bpsk = 2'b10;
        push_exp(2'b01, 16'd5, 1'b0);
        push_exp(2'b10, 16'd9, 1'b1);
        req = 2'b11;
        wait_grant(n);
        eg = exp_grant_q.pop_front();
        el = exp_len_q.pop_front();
        eu = exp_user_q.pop_front();
        tests++;
        if ({grant, payload_length, m_tuser} !== {eg, el, eu}) begin
            fails++;
            $display("FAIL rr_first got=%b/%0d/%b exp=%b/%0d/%b",
                     grant, payload_length, m_tuser, eg, el, eu);
        end
        s_len = {16'd77, 16'd66};
        s_bpsk = 2'b01;
        req = 2'b00;
        step();
        tests++;
        if (payload_length !== 16'd5 || m_tuser !== 1'b0
            || grant !== 2'b01) begin
            fails++;
            $display("FAIL len_stable got=%0d/%b/%b exp=5/0/01",
                     payload_length, m_tuser, grant);
        end
        s_len = {16'd9, 16'd5};
        s_bpsk = 2'b10;
        req = 2'b11;
        send_beats(0, 3, 8'h40);
        pulse_sent();
        count_gap(n);
        wait_grant(n);
        eg = exp_grant_q.pop_front();
        el = exp_len_q.pop_front();
        eu = exp_user_q.pop_front();
        tests++;
        if ({grant, payload_length, m_tuser} !== {eg, el, eu} || n != 1) begin
            fails++;
            $display("FAIL rr_second got=%b/%0d/%b/%0d exp=%b/%0d/%b/1",
                     grant, payload_length, m_tuser, n, eg, el, eu);
        end
        req = 2'b00;
        send_beats(1, 2, 8'h60);
        pulse_sent();
        count_gap(n);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1:0] eg;
        logic [15:0] el;
        logic eu;
        do_reset();
        step();
        s_len = {16'd2, 16'd1};
        s_bpsk = 2'b01;
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            if (p % 2 == 0) push_exp(2'b01, 16'd1, 1'b1);
            else push_exp(2'b10, 16'd2, 1'b0);
        end
        for (int p = 0; p < 4; p++) begin
            wait_grant(n);
            eg = exp_grant_q.pop_front();
            el = exp_len_q.pop_front();
            eu = exp_user_q.pop_front();
            tests++;
            if ({grant, payload_length, m_tuser} !== {eg, el, eu}) begin
                fails++;
                $display("FAIL b2b_grant%0d got=%b/%0d/%b exp=%b/%0d/%b",
                         p, grant, payload_length, m_tuser, eg, el, eu);
            end
            send_beats(p % 2, 2, 8'h80 + 8'(p * 4));
            pulse_sent();
            count_gap(n);
        end
        req = 2'b00;
    endtask

    task automatic test_timeout_tie();
        int n;
        do_reset();
        step();
        req = 2'b01;
        wait_grant(n);
        req = 2'b00;
        repeat (TO - 1) step();
        tests++;
        if (grant !== 2'b01 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL wd_last_cycle got=%b/%b exp=01/0",
                     grant, timeout_err);
        end
        pulse_sent();
        tests++;
        if (grant !== 2'b00 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL tie_pkt_wins got=%b/%b/%b exp=00/0/1",
                     grant, timeout_err, busy);
        end
        count_gap(n);
    endtask

    task automatic test_timeout();
        int n;
        bit early;
        do_reset();
        step();
        req = 2'b01;
        wait_grant(n);
        req = 2'b00;
        early = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (timeout_err !== 1'b0 || grant !== 2'b01) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL wd_early got=1 exp=0");
        end
        step();
        tests++;
        if (timeout_err !== 1'b1 || grant !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wd_fire got=%b/%b/%b exp=1/00/1",
                     timeout_err, grant, busy);
        end
        count_gap(n);
        tests++;
        if (n != GAP || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL wd_sticky got=%0d/%b exp=%0d/1",
                     n, timeout_err, GAP);
        end
        req = 2'b10;
        wait_grant(n);
        req = 2'b00;
        pulse_sent();
        count_gap(n);
        tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_sticky2 got=%b/%b exp=1/0", timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        logic [1:0] eg;
        logic [15:0] el;
        logic eu;
        do_reset();
        step();
        s_len = {16'd12, 16'd0};
        s_bpsk = 2'b00;
        push_exp(2'b10, 16'd12, 1'b0);
        req = 2'b10;
        wait_grant(n);
        eg = exp_grant_q.pop_front();
        el = exp_len_q.pop_front();
        eu = exp_user_q.pop_front();
        tests++;
        if ({grant, payload_length, m_tuser} !== {eg, el, eu}) begin
            fails++;
            $display("FAIL src1_grant got=%b/%0d/%b exp=%b/%0d/%b",
                     grant, payload_length, m_tuser, eg, el, eu);
        end
        req = 2'b00;
        m_tready = 1'b0;
        s_tvalid = 2'b11;
        s_tlast = 2'b01;
        s_tdata = {8'hC3, 8'h3C};
        #1;
        tests++;
        if (s_tready !== 2'b00 || m_tvalid !== 1'b1 || m_tdata !== 8'hC3
            || m_tlast !== 1'b0) begin
            fails++;
            $display("FAIL mready_low got=%b/%b/%h/%b exp=00/1/c3/0",
                     s_tready, m_tvalid, m_tdata, m_tlast);
        end
        m_tready = 1'b1;
        exp_beat_q.push_back({1'b0, 8'hC3});
        #1;
        tests++;
        if (s_tready !== 2'b10) begin
            fails++;
            $display("FAIL mready_high got=%b exp=10", s_tready);
        end
        step();
        s_tvalid = 2'b00;
        s_tlast = 2'b00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++;
        if ({grant, busy, payload_length, m_tuser, mode_ctrl, timeout_err,
             m_tvalid, s_tready} !== RST_VEC) begin
            fails++;
            $display("FAIL reset_mid_send got=%h exp=%h",
                     {grant, busy, payload_length, m_tuser, mode_ctrl,
                      timeout_err, m_tvalid, s_tready}, RST_VEC);
        end
    endtask

    task automatic test_gap_freeze();
        int n;
        do_reset();
        step();
        req = 2'b01;
        wait_grant(n);
        req = 2'b00;
        pulse_sent();
        repeat (5) step();
        clk_enable = 1'b0;
        req = 2'b10;
        repeat (5) step();
        tests++;
        if (busy !== 1'b1 || grant !== 2'b00 || mode_ctrl !== 4'b0100) begin
            fails++;
            $display("FAIL freeze_hold got=%b/%b/%b exp=1/00/0100",
                     busy, grant, mode_ctrl);
        end
        req = 2'b00;
        clk_enable = 1'b1;
        count_gap(n);
        tests++;
        if (n + 5 != GAP) begin
            fails++;
            $display("FAIL freeze_total got=%0d exp=%0d", n + 5, GAP);
        end
        clk_enable = 1'b0;
        req = 2'b10;
        repeat (2) step();
        tests++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_frozen got=%b/%b exp=00/0", grant, busy);
        end
        clk_enable = 1'b1;
        step();
        tests++;
        if (grant !== 2'b10) begin
            fails++;
            $display("FAIL idle_resume got=%b exp=10", grant);
        end
        req = 2'b00;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        clk_enable = 1'b1;
        req = 2'b00;
        s_len = 32'd0;
        s_bpsk = 2'b00;
        s_tdata = '0;
        s_tvalid = 2'b00;
        s_tlast = 2'b00;
        m_tready = 1'b1;
        pkt_sent = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_rr_after_reset();
        test_back_to_back();
        test_timeout_tie();
        test_timeout();
        test_reset_mid_send();
        test_gap_freeze();
        tests++;
        if (exp_beat_q.size() != 0) begin
            fails++;
            $display("FAIL beats_drained got=%0d exp=0", exp_beat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
